fifo_burst_reader: RTL
======================

# fifo_burst_reader

Read-side controller for the dual-clock sample FIFO feeding the audio FFT/FIR path. Waits for the FIFO to reach its almost-full watermark, drains it in bursts until almost-empty, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents samples as a valid/ready stream with optional frame markers. It sits in the FIFO's read clock domain, between the FIFO read port and the FFT input.

## Interface

- DATA_W, 31, sample width; matches FIFO data width
- FRAME_LEN, 1024, beats per frame for m_last; power of two, 2..65536
- sys_clk  in  1  read-domain clock
- sys_rstn  in  1  reset; asynchronous, active-low
- enable  in  1  allows new bursts to start
- fifo_rd_en  out  1  FIFO read strobe
- fifo_rd_data  in  DATA_W  FIFO read data, valid one cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty
- fifo_almost_empty  in  1  FIFO almost-empty watermark
- fifo_almost_full  in  1  FIFO almost-full watermark
- m_data  out  DATA_W  output sample
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts
- m_last  out  1  last beat of frame
- busy  out  1  state is BURST or DRAIN

## Operation

- FSM states: IDLE, WAIT_FILL, BURST, DRAIN.
- IDLE -> WAIT_FILL when enable=1.
- WAIT_FILL -> BURST when fifo_almost_full=1 and enable=1; WAIT_FILL -> IDLE when enable=0.
- BURST: fifo_rd_en=1 iff fifo_empty=0 and (buf_count + inflight - pop) <= 1, where inflight = fifo_rd_en of previous cycle and pop = m_valid & m_ready.
- BURST -> DRAIN when fifo_almost_empty=1 or enable=0; fifo_rd_en=0 in that same cycle.
- DRAIN: no reads issued; -> WAIT_FILL (enable=1) or IDLE (enable=0) once inflight=0 and buf_count=0.
- fifo_rd_en is never asserted while fifo_empty=1.
- Output buffer: 2-entry FIFO; push = inflight (captures fifo_rd_data); head drives m_data; m_valid = buf_count!=0. Simultaneous push and pop with count 2 cannot occur by credit rule.
- m_data/m_last held stable while m_valid=1 and m_ready=0.
- Frame counter: increments on each pop; wraps FRAME_LEN-1 -> 0. Not cleared by state changes, only by reset.

## Timing

- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0, state=IDLE, buf_count=0, inflight=0, frame counter=0.
- Read latency: fifo_rd_en at cycle t -> m_valid=1 at t+1 (buffer previously empty).
- Sustained throughput: 1 beat/cycle with m_ready held 1.
- Backpressure: m_ready=0 stops fifo_rd_en within 1 cycle; no sample lost or duplicated.
- almost_full and almost_empty asserted together: almost_empty wins in BURST, almost_full wins in WAIT_FILL.
- Reset mid-burst: all state cleared asynchronously; buffered/in-flight samples discarded.

## Configuration

- FBR_FRAME_LAST_EN defined: frame counter present; m_last=1 on the beat whose counter value is FRAME_LEN-1, qualified with m_valid.
- Undefined: frame counter omitted; m_last tied 0.

## Test plan

- Reset: sys_rstn=0 mid-run -> all outputs 0 immediately, state IDLE; released -> no fifo_rd_en until enable=1 and almost_full=1.
- Burst: enable=1, FIFO holds 0..999, almost_full at 900, almost_empty at 16, m_ready=1 -> contiguous m_data 0..983 one per cycle, first beat one cycle after first fifo_rd_en; reads stop when almost_empty rises.
- Backpressure: m_ready toggles 1,0,0,1 pseudo-randomly -> output sequence identical to input, never more than 2 beats buffered, no read while buffer full.
- Empty guard: force fifo_empty=1 mid-burst -> fifo_rd_en=0 that cycle; resumes when empty drops.
- Enable drop: enable=0 mid-burst -> no new reads next cycle, buffered beats delivered, busy falls after last pop, state IDLE.
- Frame (FBR_FRAME_LAST_EN, FRAME_LEN=8): stream 20 beats -> m_last on beats 7 and 15 only; macro undefined -> m_last always 0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Burst read controller for the dual-clock sample FIFO. It presents samples as a valid/ready stream.
// Optional frame marker (m_last) is built when FBR_FRAME_LAST_EN is defined.
module fifo_burst_reader #(
  parameter int unsigned DATA_W    = 31,
  parameter int unsigned FRAME_LEN = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              enable,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  input  logic              fifo_almost_empty,
  input  logic              fifo_almost_full,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StWaitFill, StBurst, StDrain} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic              r_inflight;
  logic [1:0]        r_count;
  logic              r_head;
  logic [DATA_W-1:0] r_buf [2];

  logic       w_pop;
  logic       w_store;
  logic       w_take;
  logic [2:0] w_credit;

  // The in-flight read word is bypassed to the output, so the first beat is
  // valid the cycle after fifo_rd_en. It is latched only if it is not consumed.
  assign m_valid  = (r_count != 2'd0) | r_inflight;
  assign w_pop    = m_valid & m_ready;
  assign m_data   = (r_count != 2'd0) ? r_buf[r_head] : (r_inflight ? fifo_rd_data : '0);
  assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_store  = r_inflight & ~(w_pop & (r_count == 2'd0));
  assign w_take   = w_pop & (r_count != 2'd0);
  assign busy     = (r_state == StBurst) | (r_state == StDrain);

  always_comb begin
    w_state_next = r_state;
    fifo_rd_en   = 1'b0;
    case (r_state)
      StIdle: begin
        if (enable) w_state_next = StWaitFill;
      end
      StWaitFill: begin
        if (!enable) w_state_next = StIdle;
        else if (fifo_almost_full) w_state_next = StBurst;
      end
      StBurst: begin
        if (fifo_almost_empty || !enable) begin
          w_state_next = StDrain;
        end else begin
          fifo_rd_en = ~fifo_empty & (w_credit <= 3'd1);
        end
      end
      StDrain: begin
        if (!r_inflight && (r_count == 2'd0)) begin
          w_state_next = enable ? StWaitFill : StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state    <= StIdle;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= fifo_rd_en;
      // The credit rule guarantees r_count < 2 whenever a word is stored.
      if (w_store) r_buf[r_head ^ r_count[0]] <= fifo_rd_data;
      if (w_take) r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_store} - {1'b0, w_take};
    end
  end

`ifdef FBR_FRAME_LAST_EN
  localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [CntW-1:0] r_frame_cnt;

  // FRAME_LEN is a power of two, so the counter wraps on its own.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_frame_cnt <= '0;
    end else if (w_pop) begin
      r_frame_cnt <= r_frame_cnt + CntW'(1);
    end
  end

  assign m_last = m_valid & (r_frame_cnt == CntW'(FRAME_LEN - 1));
`else
  logic w_unused_frame_len;

  assign w_unused_frame_len = ^FRAME_LEN;
  assign m_last             = 1'b0;
`endif

endmodule
